pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised program-counter generator for the fetch stage; next generation of the single-issue PC register.
- Generalises address width, reset vector and fetch width (instructions per fetch group), and adds a fetch-ready handshake to instruction memory.
- Holds a branch redirect that arrives during a stall, so it is applied when the stall releases instead of being lost.
- Flags misaligned redirect targets to the exception logic.

Parameters:
- ADDR_W, 32, PC width in bits.
- RESET_VEC, 32'h00000000, first fetch address after reset (ADDR_W bits).
- INST_BYTES, 4, bytes per instruction; power of two.
- FETCH_WIDTH, 1, instructions per fetch group; legal values 1, 2, 4.
- STALL_W, 6, width of the pipeline stall vector; only bit 0 is used here.

Ports:
- clk  in  1  clock; every register updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  STALL_W  pipeline stall vector; bit 0 = hold PC.
- flush  in  1  exception/eret redirect, highest priority.
- new_pc  in  ADDR_W  flush target.
- branch_flag_i  in  1  branch/jump taken.
- branch_target_address_i  in  ADDR_W  branch target.
- if_ready_i  in  1  instruction memory accepts the current fetch address.
- pc  out  ADDR_W  current fetch address.
- ce  out  1  fetch enable.
- lane_valid_o  out  FETCH_WIDTH  valid lanes of the current fetch group.
- misalign_o  out  1  one-cycle pulse: redirect target not instruction-aligned.
- pend_valid_o  out  1  a held branch redirect is pending.

Behaviour:
- Constants: STEP = INST_BYTES*FETCH_WIDTH. GRP_MASK = STEP-1. IMASK = INST_BYTES-1.
- Reset (rst=1 at a clock edge):
  - pc <= RESET_VEC, ce <= 0, pend_valid <= 0, pend_target <= 0, misalign_o <= 0.
  - state <= S_BOOT.
  - rst asserted mid-operation overrides everything in that cycle, including flush and branch.
- FSM states: S_BOOT, S_RUN, S_HOLD.
  - S_BOOT -> S_RUN on the first edge with rst=0; ce <= 1 and pc stays RESET_VEC. First fetch address is RESET_VEC, valid one cycle after rst deasserts.
  - S_RUN -> S_HOLD when a branch is latched while not advancing.
  - S_HOLD -> S_RUN when the pending redirect is consumed, or on flush.
- advance = ce & ~stall[0] & if_ready_i.
- Next-PC priority (first match wins), evaluated only when ce=1:
  1. flush: pc <= new_pc, regardless of stall or ready. Clears pend_valid; state <= S_RUN.
  2. branch_flag_i & advance: pc <= branch_target_address_i. A live branch supersedes any pending one; pend_valid <= 0.
  3. branch_flag_i & ~advance: pend_target <= branch_target_address_i, pend_valid <= 1, state <= S_HOLD. pc holds. Last-wins if already pending.
  4. pend_valid & advance: pc <= pend_target, pend_valid <= 0, state <= S_RUN.
  5. advance: pc <= (pc & ~GRP_MASK) + STEP, modulo 2^ADDR_W. 0xFFFFFFFC + 4 wraps to 0.
  6. otherwise: pc holds.
- lane_valid_o (combinational from pc and ce):
  - lane i is valid iff ce=1 and i >= (pc & GRP_MASK)/INST_BYTES.
  - With FETCH_WIDTH=1 it equals ce.
- misalign_o:
  - Registered; set for one cycle when pc is loaded from a flush, branch or pending target with (target & IMASK) != 0.
  - pc is still loaded with the unaligned value; the exception unit handles it.
  - Cleared on the next cycle.
- Only bit 0 of stall is consulted. Upper bits are ignored.

Decomposition:
- Shared package/defines: ChipEnable/ChipDisable, Branch/NotBranch, NoStop/Stop, RstEnable, InstAddrBus width, FSM state encoding (S_BOOT/S_RUN/S_HOLD), default RESET_VEC.
- One sub-module: pc_redirect_hold, the pending-target register with its valid bit, load/clear/overwrite control and pend_valid_o.
- Priority mux, sequential incrementer and FSM stay in pc_gen.

Test Plan:
- Reset/boot: rst=1 for 3 cycles, then 0, RESET_VEC=32'h00000000, FETCH_WIDTH=1, ready=1 -> ce=0 and pc=0 during reset; ce=1 at the first edge after deassert; pc then steps 0x0, 0x4, 0x8.
- Branch during stall: stall[0]=1, branch_flag_i=1, target 0x100 for 1 cycle, stall released 3 cycles later -> pend_valid_o=1 while stalled, pc held; pc=0x100 on the first unstalled edge; pend_valid_o=0 after.
- Flush priority: flush=1, new_pc=0x80, with branch_flag_i=1 (target 0x200), stall[0]=1 and a pending redirect -> pc=0x80, pend_valid_o=0, no later jump to 0x200.
- Wide fetch: FETCH_WIDTH=2, branch to 0x104, ready=1 -> lane_valid_o=2'b10 at pc 0x104; next pc=0x108 with lane_valid_o=2'b11; then pc=0x110.
- Handshake and wrap: pc=0xFFFFFFFC, if_ready_i low 2 cycles then high -> pc holds 2 cycles, then becomes 0x00000000.
- Misalign: branch to 0x102 -> pc=0x102 and misalign_o pulses exactly 1 cycle.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared constants and FSM encoding for the fetch PC generator
package pc_gen_pkg;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic Branch      = 1'b1;
  localparam logic NotBranch   = 1'b0;
  localparam logic NoStop      = 1'b0;
  localparam logic Stop        = 1'b1;
  localparam logic RstEnable   = 1'b1;

  localparam int InstAddrBusW = 32;
  localparam logic [InstAddrBusW-1:0] DefResetVec = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } pc_state_e;
endpackage

// File: rtl/pc_redirect_hold.sv
// rtl/pc_redirect_hold.sv - holds a branch target that arrived while fetch could not advance
module pc_redirect_hold
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic              clear_i,
  output logic              pend_valid_o,
  output logic [ADDR_W-1:0] pend_target_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] target_q, target_d;

  // A new load overwrites any older pending target (last branch wins).
  always_comb begin
    valid_d  = valid_q;
    target_d = target_q;
    if (load_i) begin
      valid_d  = 1'b1;
      target_d = target_i;
    end else if (clear_i) begin
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      valid_q  <= 1'b0;
      target_q <= '0;
    end else begin
      valid_q  <= valid_d;
      target_q <= target_d;
    end
  end

  assign pend_valid_o  = valid_q;
  assign pend_target_o = target_q;

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program counter with stall-safe redirect hold and group fetch
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(DefResetVec),
  parameter int                INST_BYTES  = 4,
  parameter int                FETCH_WIDTH = 1,
  parameter int                STALL_W     = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic                   flush,
  input  logic [ADDR_W-1:0]      new_pc,
  input  logic                   branch_flag_i,
  input  logic [ADDR_W-1:0]      branch_target_address_i,
  input  logic                   if_ready_i,
  output logic [ADDR_W-1:0]      pc,
  output logic                   ce,
  output logic [FETCH_WIDTH-1:0] lane_valid_o,
  output logic                   misalign_o,
  output logic                   pend_valid_o
);

  localparam int                IB_LOG   = $clog2(INST_BYTES);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(INST_BYTES * FETCH_WIDTH);
  localparam logic [ADDR_W-1:0] GRP_MASK = STEP - ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IMASK    = ADDR_W'(INST_BYTES - 1);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ce_q, ce_d;
  logic              mis_q, mis_d;
  logic              advance;
  logic              hold_load, hold_clear;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_target;
  logic [ADDR_W-1:0] lane_off;
  logic              unused_stall_hi;

  assign unused_stall_hi = ^stall[STALL_W-1:1];
  assign advance = (ce_q == ChipEnable) && (stall[0] == NoStop) && if_ready_i;

  function automatic logic misaligned(input logic [ADDR_W-1:0] a);
    return (a & IMASK) != '0;
  endfunction

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ce_d       = ce_q;
    mis_d      = 1'b0;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    if (state_q == S_BOOT) begin
      ce_d    = ChipEnable;
      state_d = S_RUN;
    end else if (flush) begin
      pc_d       = new_pc;
      mis_d      = misaligned(new_pc);
      hold_clear = 1'b1;
      state_d    = S_RUN;
    end else if (branch_flag_i == Branch && advance) begin
      pc_d       = branch_target_address_i;
      mis_d      = misaligned(branch_target_address_i);
      hold_clear = 1'b1;
      state_d    = S_RUN;
    end else if (branch_flag_i != NotBranch) begin
      hold_load = 1'b1;
      state_d   = S_HOLD;
    end else if (pend_valid && advance) begin
      pc_d       = pend_target;
      mis_d      = misaligned(pend_target);
      hold_clear = 1'b1;
      state_d    = S_RUN;
    end else if (advance) begin
      // Realign to the group base so an entry mid-group lands on the next group.
      pc_d = (pc_q & ~GRP_MASK) + STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VEC;
      ce_q    <= ChipDisable;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ce_q    <= ce_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    lane_valid_o = '0;
    lane_off     = (pc_q & GRP_MASK) >> IB_LOG;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      lane_valid_o[i] = ce_q && (ADDR_W'(i) >= lane_off);
    end
  end

  pc_redirect_hold #(.ADDR_W(ADDR_W)) u_hold (
    .clk           (clk),
    .rst           (rst),
    .load_i        (hold_load),
    .target_i      (branch_target_address_i),
    .clear_i       (hold_clear),
    .pend_valid_o  (pend_valid),
    .pend_target_o (pend_target)
  );

  assign pc           = pc_q;
  assign ce           = ce_q;
  assign misalign_o   = mis_q;
  assign pend_valid_o = pend_valid;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen with single and dual-lane fetch instances
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        br;
  logic [31:0] bt;
  logic        rdy;

  logic [31:0] pc1, pc2;
  logic        ce1, ce2;
  logic [0:0]  lv1;
  logic [1:0]  lv2;
  logic        mis1, mis2, pv1, pv2;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  pc_gen #(.ADDR_W(32), .RESET_VEC(32'h0), .INST_BYTES(4), .FETCH_WIDTH(1), .STALL_W(6)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag_i(br), .branch_target_address_i(bt), .if_ready_i(rdy),
    .pc(pc1), .ce(ce1), .lane_valid_o(lv1), .misalign_o(mis1), .pend_valid_o(pv1)
  );

  pc_gen #(.ADDR_W(32), .RESET_VEC(32'h0), .INST_BYTES(4), .FETCH_WIDTH(2), .STALL_W(6)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag_i(br), .branch_target_address_i(bt), .if_ready_i(rdy),
    .pc(pc2), .ce(ce2), .lane_valid_o(lv2), .misalign_o(mis2), .pend_valid_o(pv2)
  );

  // Reference model: index 0 is the one-lane instance, index 1 the two-lane one.
  logic [31:0] m_pc[2];
  logic [31:0] m_pt[2];
  bit          m_ce[2];
  bit          m_pv[2];
  bit          m_mis[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] m_lane(input int k);
    logic [1:0] r;
    int fw;
    int off;
    r   = '0;
    fw  = k + 1;
    off = int'(m_pc[k] % (4 * fw)) / 4;
    for (int i = 0; i < fw; i++) begin
      if (m_ce[k] && i >= off) r[i] = 1'b1;
    end
    return r;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      longint step;
      bit     adv;
      step     = 4 * (k + 1);
      adv      = m_ce[k] && !stall[0] && rdy;
      m_mis[k] = 1'b0;
      if (rst) begin
        m_pc[k] = 32'h0; m_ce[k] = 1'b0; m_pv[k] = 1'b0; m_pt[k] = 32'h0;
      end else if (!m_ce[k]) begin
        m_ce[k] = 1'b1;
      end else if (flush) begin
        m_pc[k] = new_pc; m_pv[k] = 1'b0; m_mis[k] = (new_pc % 4) != 0;
      end else if (br && adv) begin
        m_pc[k] = bt; m_pv[k] = 1'b0; m_mis[k] = (bt % 4) != 0;
      end else if (br) begin
        m_pt[k] = bt; m_pv[k] = 1'b1;
      end else if (m_pv[k] && adv) begin
        m_pc[k] = m_pt[k]; m_pv[k] = 1'b0; m_mis[k] = (m_pt[k] % 4) != 0;
      end else if (adv) begin
        m_pc[k] = 32'((longint'(m_pc[k]) / step) * step + step);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model pc1",   pc1,        m_pc[0]);
    chk("model ce1",   ce1,        m_ce[0]);
    chk("model lane1", {31'b0, lv1}, {30'b0, m_lane(0)});
    chk("model pend1", pv1,        m_pv[0]);
    chk("model mis1",  mis1,       m_mis[0]);
    chk("model pc2",   pc2,        m_pc[1]);
    chk("model ce2",   ce2,        m_ce[1]);
    chk("model lane2", {30'b0, lv2}, {30'b0, m_lane(1)});
    chk("model pend2", pv2,        m_pv[1]);
    chk("model mis2",  mis2,       m_mis[1]);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; stall = 6'h0; flush = 1'b0; new_pc = 32'h0;
    br = 1'b0; bt = 32'h0; rdy = 1'b1;
  endtask

  typedef struct {
    bit          rst;
    logic [5:0]  stall;
    bit          flush;
    logic [31:0] npc;
    bit          br;
    logic [31:0] bt;
    bit          rdy;
    logic [31:0] e_pc;
    bit          e_ce;
    bit          e_pv;
    bit          e_mis;
  } vec_t;

  vec_t vt[$];

  initial begin
    idle_inputs();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = '0; m_pt[k] = '0; m_ce[k] = 0; m_pv[k] = 0; m_mis[k] = 0;
    end

    //                 rst stall  fl npc         br bt          rdy  e_pc         ce pv mis
    vt.push_back(vec_t'{1, 6'h00, 0, 32'h0,      0, 32'h0,      1,   32'h0,       0, 0, 0});
    vt.push_back(vec_t'{1, 6'h00, 0, 32'h0,      0, 32'h0,      1,   32'h0,       0, 0, 0});
    vt.push_back(vec_t'{1, 6'h00, 0, 32'h0,      0, 32'h0,      1,   32'h0,       0, 0, 0});
    vt.push_back(vec_t'{0, 6'h00, 0, 32'h0,      0, 32'h0,      1,   32'h0,       1, 0, 0});
    vt.push_back(vec_t'{0, 6'h00, 0, 32'h0,      0, 32'h0,      1,   32'h4,       1, 0, 0});
    vt.push_back(vec_t'{0, 6'h00, 0, 32'h0,      0, 32'h0,      1,   32'h8,       1, 0, 0});
    vt.push_back(vec_t'{0, 6'h01, 0, 32'h0,      1, 32'h100,    1,   32'h8,       1, 1, 0});
    vt.push_back(vec_t'{0, 6'h01, 0, 32'h0,      0, 32'h0,      1,   32'h8,       1, 1, 0});
    vt.push_back(vec_t'{0, 6'h01, 0, 32'h0,      0, 32'h0,      1,   32'h8,       1, 1, 0});
    vt.push_back(vec_t'{0, 6'h00, 0, 32'h0,      0, 32'h0,      1,   32'h100,     1, 0, 0});
    vt.push_back(vec_t'{0, 6'h3E, 0, 32'h0,      0, 32'h0,      1,   32'h104,     1, 0, 0});
    vt.push_back(vec_t'{0, 6'h01, 0, 32'h0,      1, 32'h300,    1,   32'h104,     1, 1, 0});
    vt.push_back(vec_t'{0, 6'h01, 1, 32'h80,     1, 32'h200,    1,   32'h80,      1, 0, 0});
    vt.push_back(vec_t'{0, 6'h00, 0, 32'h0,      0, 32'h0,      1,   32'h84,      1, 0, 0});
    vt.push_back(vec_t'{0, 6'h00, 0, 32'h0,      0, 32'h0,      1,   32'h88,      1, 0, 0});
    vt.push_back(vec_t'{0, 6'h00, 0, 32'h0,      1, 32'h102,    1,   32'h102,     1, 0, 1});
    vt.push_back(vec_t'{0, 6'h00, 0, 32'h0,      0, 32'h0,      1,   32'h104,     1, 0, 0});
    vt.push_back(vec_t'{0, 6'h00, 1, 32'h81,     0, 32'h0,      1,   32'h81,      1, 0, 1});
    vt.push_back(vec_t'{0, 6'h01, 0, 32'h0,      0, 32'h0,      1,   32'h81,      1, 0, 0});
    vt.push_back(vec_t'{1, 6'h00, 1, 32'h40,     1, 32'h200,    1,   32'h0,       0, 0, 0});
    vt.push_back(vec_t'{0, 6'h00, 0, 32'h0,      0, 32'h0,      1,   32'h0,       1, 0, 0});

    foreach (vt[i]) begin
      rst = vt[i].rst; stall = vt[i].stall; flush = vt[i].flush; new_pc = vt[i].npc;
      br = vt[i].br; bt = vt[i].bt; rdy = vt[i].rdy;
      tick();
      chk($sformatf("vec%0d pc", i),   pc1,  vt[i].e_pc);
      chk($sformatf("vec%0d ce", i),   ce1,  vt[i].e_ce);
      chk($sformatf("vec%0d pend", i), pv1,  vt[i].e_pv);
      chk($sformatf("vec%0d mis", i),  mis1, vt[i].e_mis);
    end

    // Two-lane fetch entering mid-group.
    idle_inputs();
    br = 1'b1; bt = 32'h104;
    tick();
    br = 1'b0;
    chk("wide pc 104",   pc2, 32'h104);
    chk("wide lane 104", lv2, 2'b10);
    tick();
    chk("wide pc 108",   pc2, 32'h108);
    chk("wide lane 108", lv2, 2'b11);
    tick();
    chk("wide pc 110",   pc2, 32'h110);
    chk("wide lane 110", lv2, 2'b11);

    // Ready handshake holding at the top of the address space, then wrap.
    flush = 1'b1; new_pc = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    chk("wrap pc1 top",  pc1, 32'hFFFF_FFFC);
    chk("wrap lane2 top", lv2, 2'b10);
    rdy = 1'b0;
    tick();
    chk("wrap hold1 pc1", pc1, 32'hFFFF_FFFC);
    tick();
    chk("wrap hold2 pc1", pc1, 32'hFFFF_FFFC);
    rdy = 1'b1;
    tick();
    chk("wrap pc1 zero", pc1, 32'h0);
    chk("wrap pc2 zero", pc2, 32'h0);

    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 49) == 0);
      stall    = 6'($urandom);
      stall[0] = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      new_pc   = $urandom;
      if ($urandom_range(0, 1) == 1) new_pc[1:0] = 2'b00;
      br       = ($urandom_range(0, 5) == 0);
      bt       = $urandom;
      if ($urandom_range(0, 1) == 1) bt[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) bt[31:8] = '1;
      rdy      = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
